mult_product_accumulator: RTL
=============================

Name: mult_product_accumulator

Overview:
- Downstream consumer of the 16-bit product bus of the 8x8 unsigned array multiplier.
- Accepts a run of LEN products over a valid/ready handshake and sums them into a saturating accumulator.
- Presents the dot-product result over a valid/ready output handshake.
- Turns the combinational multiplier into a sequential multiply-accumulate datapath for vector dot products.

Parameters:
ACC_W, 24, accumulator/result width in bits (must be >= 16)
LEN_W, 4, width of the run-length input; runs of 0..(2^LEN_W - 1) products

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a run; sampled only in IDLE
len  input  LEN_W  number of products in the run; latched on accepted start
product  input  16  unsigned product from the multiplier's sum[15:0]
in_valid  input  1  product is valid this cycle
in_ready  output  1  block accepts a product this cycle
result  output  ACC_W  accumulated sum, registered
overflow  output  1  sticky: saturation occurred during this run
out_valid  output  1  result/overflow valid
out_ready  input  1  downstream takes the result
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0, count=0, len_q=0, overflow=0; result=0, out_valid=0, in_ready=0, busy=0. Takes effect immediately, including mid-run; partial sums are discarded.
- States: IDLE, ACCUM, DONE. in_ready = (state==ACCUM). out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE:
  - On start=1: len_q<=len, acc<=0, count<=0, overflow<=0.
  - If len==0: go to DONE with result=0.
  - Otherwise: go to ACCUM.
  - in_valid is ignored in IDLE, including the start cycle (in_ready=0).
- ACCUM:
  - Accept = in_valid & in_ready.
  - On accept: sum = acc + zero-extend(product), computed at ACC_W+1 bits.
    - If sum[ACC_W]=1: acc<=all ones, overflow<=1.
    - Else: acc<=sum[ACC_W-1:0].
    - count<=count+1.
  - If the accept is the last one (count==len_q-1): result<=saturated sum, state<=DONE.
  - Without in_valid, the block holds all state indefinitely.
  - start is ignored.
- DONE:
  - result and overflow are stable while out_valid=1.
  - On out_ready=1: go to IDLE in the next cycle; result holds its value; overflow holds until the next start.
  - start is ignored in DONE, including a start coinciding with the out_ready cycle; a new run starts no earlier than the cycle after the return to IDLE.
- Latency:
  - start -> in_ready=1 in the next cycle.
  - Last accept -> out_valid=1 in the next cycle.
  - Minimum run length is LEN+2 cycles with back-to-back products and out_ready held high.
- Once saturated, acc stays at all ones for the rest of the run; no wrap-around.
- The count register is LEN_W bits and never exceeds len_q-1 while in ACCUM.

Test Plan:
- Reset mid-run: len=4, accept 2 products, then assert rst asynchronously between edges -> all outputs 0 immediately, state IDLE; a subsequent run with len=1, product=7 -> result=7.
- Basic dot product: start, len=3, products 6 (2*3), 20 (4*5), 42 (6*7) back-to-back, out_ready=1 -> out_valid 1 cycle after the third accept, result=68, overflow=0, busy low again the cycle after.
- Handshake stalls: len=4, products 65025 each with in_valid toggling 1/0, out_ready held 0 for 5 cycles -> exactly 4 accepts, result=260100 held stable while out_valid=1 for the stalled cycles, single return to IDLE on out_ready.
- Zero length and ignored inputs: start with len=0 while in_valid=1, product=99 -> DONE next cycle with result=0, no product accepted; start pulses during ACCUM and DONE -> no effect on len_q or result.
- Saturation (override ACC_W=18): len=5, five products of 65025 (255*255) -> result=262143, overflow=1 set on the 5th accept; next run len=1, product=1 -> result=1, overflow=0.
- Max length (default params): len=15, all products 65025 -> result=975375, overflow=0, exactly 15 accepts.

Source files
------------

// File: rtl/mult_product_accumulator.sv
// Saturating multiply-accumulate back end: sums a run of LEN unsigned 16-bit products
// from the array multiplier and hands the dot-product result downstream over valid/ready.
module mult_product_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      product,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    // One extra bit catches the carry out so saturation needs no compare.
    logic [ACC_W:0]   sum_w;
    logic [ACC_W-1:0] sat_w;
    logic             last_w;

    assign sum_w  = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, product};
    assign sat_w  = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    assign last_w = (count_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            len_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            len_q    <= len_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        len_d    = len_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (len == '0) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d   = sat_w;
                    count_d = count_q + LEN_W'(1);
                    if (sum_w[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
                    if (last_w) begin
                        result_d = sat_w;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = result_q;
    assign overflow  = ovf_q;

endmodule
